// File: rtl/seq_div_pkg.sv
// rtl/seq_div_pkg.sv - shared FSM state type and default widths for seq_div_usign
package seq_div_pkg;

  localparam int N_DEF = 32;
  localparam int M_DEF = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/seq_div_usign_if.sv
// rtl/seq_div_usign_if.sv - start/operand/result bundle between a requester and seq_div_usign
interface seq_div_usign_if
  import seq_div_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int M = M_DEF
);

  logic         start;
  logic [N-1:0] A;
  logic [M-1:0] B;
  logic         busy;
  logic         done;
  logic [N-1:0] Q;
  logic [M-1:0] R;

  modport master (
    output start, A, B,
    input  busy, done, Q, R
  );

  modport slave (
    input  start, A, B,
    output busy, done, Q, R
  );

endinterface

// File: rtl/seq_div_step.sv
// rtl/seq_div_step.sv - one combinational restoring-division step (trial subtract, keep or restore)
module seq_div_step #(
  parameter int M = 11
) (
  input  logic [M-1:0] r_acc,
  input  logic         msb,
  input  logic [M-1:0] divisor,
  output logic [M-1:0] r_next,
  output logic         q_bit
);

  logic [M:0] t;

  always_comb begin
    t      = {r_acc, msb};
    q_bit  = (t >= {1'b0, divisor});
    // When the subtract succeeds the difference is below the divisor, so it fits in M bits.
    r_next = q_bit ? M'(t - {1'b0, divisor}) : t[M-1:0];
  end

endmodule

// File: rtl/seq_div_usign.sv
// rtl/seq_div_usign.sv - iterative radix-2 unsigned divider; SEQ_DIV_ZERO_FASTPATH_EN shortens divide-by-zero
module seq_div_usign
  import seq_div_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int M = M_DEF
) (
  input  logic           clk,
  input  logic           rst,
  seq_div_usign_if.slave bus
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  div_state_t   state;
  logic [N-1:0] a_sh;
  logic [M-1:0] b_r;
  logic [M-1:0] r_acc;
  logic [CW-1:0] cnt;
  logic         div_zero;
  logic [M-1:0] a_low;
  logic         busy_r;
  logic         done_r;
  logic [N-1:0] q_r;
  logic [M-1:0] rem_r;

  logic [M-1:0] r_next;
  logic         q_bit;
  logic [N-1:0] a_next;

  seq_div_step #(.M(M)) u_step (
    .r_acc   (r_acc),
    .msb     (a_sh[N-1]),
    .divisor (b_r),
    .r_next  (r_next),
    .q_bit   (q_bit)
  );

  // Dividend bits leave at the top while quotient bits enter at the bottom.
  assign a_next = (a_sh << 1) | N'(q_bit);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_r      <= '0;
      r_acc    <= '0;
      cnt      <= '0;
      div_zero <= 1'b0;
      a_low    <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      q_r      <= '0;
      rem_r    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_sh     <= bus.A;
            b_r      <= bus.B;
            r_acc    <= '0;
            div_zero <= (bus.B == '0);
            a_low    <= bus.A[M-1:0];
            busy_r   <= 1'b1;
            state    <= RUN;
`ifdef SEQ_DIV_ZERO_FASTPATH_EN
            // A zero divisor takes a single pass through RUN so done stays registered at t+2.
            cnt      <= (bus.B == '0) ? '0 : CW'(N - 1);
`else
            cnt      <= CW'(N - 1);
`endif
          end
        end
        RUN: begin
          r_acc <= r_next;
          a_sh  <= a_next;
          cnt   <= cnt - 1'b1;
          if (cnt == '0) begin
            state  <= DONE;
            done_r <= 1'b1;
            q_r    <= div_zero ? '1 : a_next;
            rem_r  <= div_zero ? a_low : r_next;
          end
        end
        DONE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.Q    = q_r;
  assign bus.R    = rem_r;

endmodule
